// File: rtl/conf_int_pkg.sv
// conf_int_pkg: shared types and constants for the conf_int dot-product
// sequencer.
//   state_e      - sequencer FSM states
//   DRAIN_CYCLES - cycles from the final accept to result capture
//                  (MAC a/b register stage + accumulator stage + capture)
package conf_int_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4
    } state_e;

    localparam int DRAIN_CYCLES = 3;
    localparam int DRN_W        = 2;

endpackage

// File: rtl/conf_int_dot_seq_if.sv
// conf_int_dot_seq_if: operand, MAC-side and result signals of the dot-product
// sequencer, grouped into a single bundle.
//   slave  modport - the sequencer (consumes operands, drives the MAC, emits results)
//   master modport - the environment (operand source, MAC, result sink)
// Signals:
//   in_valid/in_ready/in_a/in_b/approx_mode  operand pair handshake
//   mac_racc_n/mac_rapx_n/mac_a/mac_b/mac_d  MAC connection
//   res_valid/res_ready/res_data/res_approx  result handshake
//   stall_cnt                                bubble-cycle counter
interface conf_int_dot_seq_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          approx_mode;
    logic          mac_racc_n;
    logic          mac_rapx_n;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [DW-1:0] mac_d;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_approx;
    logic [15:0]   stall_cnt;

    modport slave (
        input  in_valid, in_a, in_b, approx_mode, mac_d, res_ready,
        output in_ready, mac_racc_n, mac_rapx_n, mac_a, mac_b,
               res_valid, res_data, res_approx, stall_cnt
    );

    modport master (
        output in_valid, in_a, in_b, approx_mode, mac_d, res_ready,
        input  in_ready, mac_racc_n, mac_rapx_n, mac_a, mac_b,
               res_valid, res_data, res_approx, stall_cnt
    );

endinterface

// File: rtl/conf_int_sat_cnt.sv
// conf_int_sat_cnt: saturating up-counter with synchronous clear and enable.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset (count -> 0)
//   clr_i  - synchronous clear, wins over en_i
//   en_i   - increment by one unless already at all-ones
//   cnt_o  - current count
module conf_int_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/conf_int_dot_seq.sv
// conf_int_dot_seq: operand sequencer feeding the conf_int MAC.
// Clears the MAC accumulator at each vector start, streams VEC_LEN a/b pairs
// (zero bubbles while the source stalls), waits out the MAC pipeline and
// captures its d output as one result.  Approximate vectors hold mac_rapx_n
// low so the MAC zeroes its low slice.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   bus       - conf_int_dot_seq_if.slave (operands, MAC, result, stall_cnt)
// Optional build macro CONF_INT_DOT_SEQ_STALL_CNT_EN: when defined, stall_cnt
// counts STREAM bubble cycles (saturating); otherwise it is tied to zero.
// The bus interface DW must equal DATA_PATH_BITWIDTH.
module conf_int_dot_seq
    import conf_int_pkg::*;
#(
    parameter int OP_BITWIDTH        = 12,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int VEC_LEN            = 4,
    parameter int CNT_W              = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    conf_int_dot_seq_if.slave bus
);

    localparam int DW = DATA_PATH_BITWIDTH;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(VEC_LEN - 1);
    localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(DRAIN_CYCLES - 1);

    if ((VEC_LEN < 1) ||
        (2 * (DATA_PATH_BITWIDTH - OP_BITWIDTH) >= DATA_PATH_BITWIDTH)) begin : g_bad_cfg
        $error("conf_int_dot_seq: illegal VEC_LEN / OP_BITWIDTH configuration");
    end

    state_e           state_q;
    logic             in_ready_q;
    logic             racc_n_q;
    logic             rapx_n_q;
    logic [DW-1:0]    mac_a_q;
    logic [DW-1:0]    mac_b_q;
    logic             res_valid_q;
    logic [DW-1:0]    res_data_q;
    logic             res_approx_q;
    logic             apx_q;
    logic [DRN_W-1:0] drn_q;
    logic [CNT_W-1:0] cnt_q;

    logic acc;
    logic last_acc;
    logic bubble;

    // in_ready_q is only ever high in STREAM, so this is the accept strobe.
    assign acc      = bus.in_valid & in_ready_q;
    assign last_acc = acc & (cnt_q == LAST_PAIR);
    assign bubble   = (state_q == STREAM) & ~acc;

    conf_int_sat_cnt #(.W(CNT_W)) u_pair_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (last_acc),
        .en_i  (acc),
        .cnt_o (cnt_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            racc_n_q     <= 1'b0;
            rapx_n_q     <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_approx_q <= 1'b0;
            apx_q        <= 1'b0;
            drn_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b0;
                    mac_a_q    <= '0;
                    mac_b_q    <= '0;
                    if (bus.in_valid) begin
                        // Clear lines drop on this edge so they are low for
                        // exactly the CLEAR cycle; the pair stays pending.
                        apx_q    <= bus.approx_mode;
                        racc_n_q <= 1'b0;
                        rapx_n_q <= 1'b0;
                        state_q  <= CLEAR;
                    end else begin
                        racc_n_q <= 1'b1;
                        rapx_n_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    racc_n_q   <= 1'b1;
                    rapx_n_q   <= ~apx_q;
                    in_ready_q <= 1'b1;
                    state_q    <= STREAM;
                end
                STREAM: begin
                    // A stalled cycle feeds 0*0 so the accumulator holds.
                    mac_a_q <= acc ? bus.in_a : '0;
                    mac_b_q <= acc ? bus.in_b : '0;
                    if (last_acc) begin
                        in_ready_q <= 1'b0;
                        drn_q      <= '0;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    mac_a_q <= '0;
                    mac_b_q <= '0;
                    if (drn_q == LAST_DRN) begin
                        res_data_q   <= bus.mac_d;
                        res_approx_q <= apx_q;
                        res_valid_q  <= 1'b1;
                        state_q      <= HOLD;
                    end else begin
                        drn_q <= drn_q + DRN_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        rapx_n_q    <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CONF_INT_DOT_SEQ_STALL_CNT_EN
    conf_int_sat_cnt #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .en_i  (bubble),
        .cnt_o (bus.stall_cnt)
    );
`else
    assign bus.stall_cnt = 16'h0000;
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.mac_racc_n = racc_n_q;
    assign bus.mac_rapx_n = rapx_n_q;
    assign bus.mac_a      = mac_a_q;
    assign bus.mac_b      = mac_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_approx = res_approx_q;

endmodule

// File: tb/tb_conf_int_dot_seq.sv
// Directed bench for conf_int_dot_seq with a behavioural MAC: a/b register
// stage, accumulator stage, racc_n async clear, rapx_n low masking the low
// 4 operand bits and low 8 accumulator bits.
module tb_conf_int_dot_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    conf_int_dot_seq_if #(.DW(16)) bus ();

    conf_int_dot_seq #(
        .OP_BITWIDTH        (12),
        .DATA_PATH_BITWIDTH (16),
        .VEC_LEN            (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC model
    logic [15:0] a_r, b_r, c_r;
    logic [31:0] prod;
    logic [15:0] amask, cmask;
    assign prod  = a_r * b_r;
    assign amask = bus.mac_rapx_n ? 16'hFFFF : 16'hFFF0;
    assign cmask = bus.mac_rapx_n ? 16'hFFFF : 16'hFF00;
    always @(posedge clk or negedge bus.mac_racc_n) begin
        if (!bus.mac_racc_n) begin
            a_r <= 16'h0;
            b_r <= 16'h0;
            c_r <= 16'h0;
        end else begin
            a_r <= bus.mac_a & amask;
            b_r <= bus.mac_b & amask;
            c_r <= (c_r + prod[15:0]) & cmask;
        end
    end
    assign bus.mac_d = c_r;

`ifdef CONF_INT_DOT_SEQ_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd2;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    // Present a pair and hold it until accepted; returns on the negedge after
    // the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 16'h0;
        bus.in_b     = 16'h0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) begin
            errors++;
            $display("FAIL res_timeout: res_valid=%0b, required 1", bus.res_valid);
        end
    endtask

    task automatic pop();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready, bus.res_valid, bus.res_approx} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready, bus.res_valid, bus.res_approx});
        end
        checks++;
        if ({bus.mac_a, bus.mac_b, bus.res_data, bus.stall_cnt} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0",
                     {bus.mac_a, bus.mac_b, bus.res_data, bus.stall_cnt});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL idle_ctrl: got %b, required 110",
                     {bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready});
        end
    endtask

    task automatic test_exact();
        bus.approx_mode = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_a        = 16'd1;
        bus.in_b        = 16'd5;
        @(negedge clk);
        checks++;
        if ({bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL clear_cycle: got %b, required 000",
                     {bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready});
        end
        @(negedge clk);
        checks++;
        if ({bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL stream_entry: got %b, required 111",
                     {bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready});
        end
        send(16'd1, 16'd5);
        send(16'd2, 16'd6);
        send(16'd3, 16'd7);
        send(16'd4, 16'd8);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL latency_early[%0d]: res_valid=%b in_ready=%b, required 0 0",
                         i, bus.res_valid, bus.in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0046 || bus.res_approx !== 1'b0) begin
            errors++;
            $display("FAIL exact_result: valid=%b data=%h apx=%b, required 1 0046 0",
                     bus.res_valid, bus.res_data, bus.res_approx);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL exact_stall: got %0d, required 0", bus.stall_cnt);
        end
        pop();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL exact_pop: res_valid=%b, required 0", bus.res_valid);
        end
    endtask

    task automatic test_bubbles();
        send(16'd1, 16'd5);
        send(16'd2, 16'd6);
        repeat (2) @(negedge clk);
        send(16'd3, 16'd7);
        send(16'd4, 16'd8);
        wait_res();
        checks++;
        if (bus.res_data !== 16'h0046) begin
            errors++;
            $display("FAIL bubble_result: got %h, required 0046", bus.res_data);
        end
        checks++;
        if (bus.stall_cnt !== EXP_STALL) begin
            errors++;
            $display("FAIL bubble_stall: got %0d, required %0d", bus.stall_cnt, EXP_STALL);
        end
        pop();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF);
        wait_res();
        checks++;
        if (bus.res_data !== 16'h0004) begin
            errors++;
            $display("FAIL wrap_result: got %h, required 0004", bus.res_data);
        end
        pop();
    endtask

    task automatic test_approx();
        bus.approx_mode = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h0013, 16'h0011);
        bus.approx_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.mac_racc_n, bus.mac_rapx_n} !== 2'b10) begin
                errors++;
                $display("FAIL approx_drain_rapx[%0d]: got %b, required 10",
                         i, {bus.mac_racc_n, bus.mac_rapx_n});
            end
            @(negedge clk);
        end
        wait_res();
        checks++;
        if (bus.res_data !== 16'h0400 || bus.res_approx !== 1'b1) begin
            errors++;
            $display("FAIL approx_result: data=%h apx=%b, required 0400 1",
                     bus.res_data, bus.res_approx);
        end
        pop();
        checks++;
        if (bus.mac_rapx_n !== 1'b1) begin
            errors++;
            $display("FAIL approx_release: rapx_n=%b, required 1", bus.mac_rapx_n);
        end
        for (int i = 0; i < 4; i++) send(16'h0013, 16'h0011);
        wait_res();
        checks++;
        if (bus.res_data !== 16'h050C || bus.res_approx !== 1'b0) begin
            errors++;
            $display("FAIL approx_off_result: data=%h apx=%b, required 050c 0",
                     bus.res_data, bus.res_approx);
        end
        pop();
    endtask

    task automatic test_backpressure();
        send(16'd1, 16'd1);
        send(16'd2, 16'd1);
        send(16'd3, 16'd1);
        send(16'd4, 16'd1);
        wait_res();
        bus.in_valid = 1'b1;
        bus.in_a     = 16'd2;
        bus.in_b     = 16'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 16'd10 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h in_ready=%b, required 1 000a 0",
                         i, bus.res_valid, bus.res_data, bus.in_ready);
            end
        end
        pop();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b in_ready=%b, required 0 0",
                     bus.res_valid, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.mac_racc_n !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap_clear: in_ready=%b racc_n=%b, required 0 0",
                     bus.in_ready, bus.mac_racc_n);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_restart: in_ready=%b, required 1", bus.in_ready);
        end
        for (int i = 0; i < 4; i++) send(16'd2, 16'd3);
        wait_res();
        checks++;
        if (bus.res_data !== 16'd24) begin
            errors++;
            $display("FAIL bp_next_result: got %h, required 0018", bus.res_data);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        send(16'd5, 16'd5);
        send(16'd6, 16'd6);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready, bus.res_valid, bus.res_approx} !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_ctrl: got %b, required 00000",
                     {bus.mac_racc_n, bus.mac_rapx_n, bus.in_ready, bus.res_valid, bus.res_approx});
        end
        checks++;
        if ({bus.mac_a, bus.mac_b, bus.res_data, bus.stall_cnt} !== 64'h0) begin
            errors++;
            $display("FAIL midrst_data: got %h, required 0",
                     {bus.mac_a, bus.mac_b, bus.res_data, bus.stall_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(16'd1, 16'd2);
        wait_res();
        checks++;
        if (bus.res_data !== 16'd8) begin
            errors++;
            $display("FAIL midrst_fresh: got %h, required 0008", bus.res_data);
        end
        pop();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_a        = 16'h0;
        bus.in_b        = 16'h0;
        bus.approx_mode = 1'b0;
        bus.res_ready   = 1'b0;
        test_reset();
        test_exact();
        test_bubbles();
        test_wrap();
        test_approx();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
